// File: rtl/graphic_unit_sequencer.sv
// Scanline sequencer for a bank of graphic units: starts each enabled unit per line,
// forwards the active unit's pixel writes to the line buffer and guards each unit with a timeout.
module graphic_unit_sequencer #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned LINE_WIDTH = 320,
  parameter int unsigned NUM_LINES  = 240,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [NUM_UNITS-1:0]    unit_en,
  output logic [11:0]             dy,
  output logic [NUM_UNITS-1:0]    start,
  input  logic [NUM_UNITS-1:0]    unit_done,
  input  logic [NUM_UNITS-1:0]    unit_wr,
  input  logic [NUM_UNITS*12-1:0] unit_dx,
  input  logic [NUM_UNITS-1:0]    unit_data,
  output logic                    lb_wr,
  output logic [11:0]             lb_addr,
  output logic                    lb_data,
  output logic                    line_ready,
  output logic                    frame_done,
  output logic                    busy,
  output logic [NUM_UNITS-1:0]    timeout_err
);

  localparam int unsigned DW = 12;
  localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_NEXT, S_LINE_END
  } state_t;

  state_t               state_q, state_d;
  logic [UW-1:0]        u_q, u_d;
  logic [NUM_UNITS-1:0] mask_q, mask_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        dy_q, dy_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic                 lb_wr_q, lb_wr_d;
  logic [DW-1:0]        lb_addr_q, lb_addr_d;
  logic                 lb_data_q, lb_data_d;
  logic                 line_ready_q, line_ready_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic [NUM_UNITS-1:0] terr_q, terr_d;

  logic [DW-1:0] cur_dx_c;
  logic          cur_wr_c, cur_data_c, cur_done_c;
  logic          last_unit_c, last_line_c;

  // Only the currently selected unit is visible to the sequencer.
  always_comb begin
    cur_dx_c    = unit_dx[DW*u_q +: DW];
    cur_wr_c    = unit_wr[u_q];
    cur_data_c  = unit_data[u_q];
    cur_done_c  = unit_done[u_q];
    last_unit_c = (u_q == UW'(NUM_UNITS - 1));
    last_line_c = (dy_q == DW'(NUM_LINES - 1));
  end

  always_comb begin
    state_d      = state_q;
    u_d          = u_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    dy_d         = dy_q;
    start_d      = '0;
    lb_wr_d      = 1'b0;
    lb_addr_d    = lb_addr_q;
    lb_data_d    = lb_data_q;
    line_ready_d = 1'b0;
    frame_done_d = 1'b0;
    terr_d       = terr_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          mask_d  = unit_en;
          terr_d  = '0;
          dy_d    = '0;
          u_d     = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q[u_q]) begin
          start_d[u_q] = 1'b1;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Writes outside the visible line are dropped rather than wrapped.
        if (cur_wr_c && (32'(cur_dx_c) < LINE_WIDTH)) begin
          lb_wr_d   = 1'b1;
          lb_addr_d = cur_dx_c;
          lb_data_d = cur_data_c;
        end
        if (cur_done_c) begin
          state_d = S_NEXT;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          terr_d[u_q] = 1'b1;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_unit_c) begin
          u_d          = '0;
          line_ready_d = 1'b1;
          frame_done_d = last_line_c;
          state_d      = S_LINE_END;
        end else begin
          u_d     = u_q + UW'(1);
          state_d = S_SELECT;
        end
      end
      S_LINE_END: begin
        if (last_line_c) begin
          state_d = S_IDLE;
        end else begin
          dy_d    = dy_q + DW'(1);
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      u_q          <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      dy_q         <= '0;
      start_q      <= '0;
      lb_wr_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= 1'b0;
      line_ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      terr_q       <= '0;
    end else begin
      state_q      <= state_d;
      u_q          <= u_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      dy_q         <= dy_d;
      start_q      <= start_d;
      lb_wr_q      <= lb_wr_d;
      lb_addr_q    <= lb_addr_d;
      lb_data_q    <= lb_data_d;
      line_ready_q <= line_ready_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
    end
  end

  assign dy          = dy_q;
  assign start       = start_q;
  assign lb_wr       = lb_wr_q;
  assign lb_addr     = lb_addr_q;
  assign lb_data     = lb_data_q;
  assign line_ready  = line_ready_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_graphic_unit_sequencer.sv
// Scoreboard bench: stimulus pushes expected starts/writes/lines into queues, a monitor pops and compares.
module tb_graphic_unit_sequencer;

  localparam int unsigned NU = 4;
  localparam int unsigned LW = 320;
  localparam int unsigned NL = 240;
  localparam int unsigned TO = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [NU-1:0] unit_en;
  logic [11:0]   dy;
  logic [NU-1:0] start;
  logic [NU-1:0] unit_done;
  logic [NU-1:0] unit_wr;
  logic [NU*12-1:0] unit_dx;
  logic [NU-1:0] unit_data;
  logic          lb_wr;
  logic [11:0]   lb_addr;
  logic          lb_data;
  logic          line_ready;
  logic          frame_done;
  logic          busy;
  logic [NU-1:0] timeout_err;

  graphic_unit_sequencer #(
    .NUM_UNITS(NU), .LINE_WIDTH(LW), .NUM_LINES(NL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .unit_en(unit_en),
    .dy(dy), .start(start), .unit_done(unit_done), .unit_wr(unit_wr),
    .unit_dx(unit_dx), .unit_data(unit_data), .lb_wr(lb_wr), .lb_addr(lb_addr),
    .lb_data(lb_data), .line_ready(line_ready), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] line;
    logic [1:0]  unit;
    logic        first_line;
    logic        first_frame;
  } st_exp_t;

  st_exp_t     start_q[$];
  logic [12:0] lb_q[$];
  logic [12:0] line_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   last_done_cyc = 0;
  int   prev_unit = 0;
  int   lb_cnt = 0;
  int   lr_cnt = 0;
  int   scen = 0;
  logic abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start, write or line pulse.
  initial begin : monitor
    st_exp_t     e;
    logic [12:0] w;
    forever begin
      @(negedge clk);
      if (start != '0) begin
        if (start_q.size() == 0) chk("start_unexpected", 64'(start), 64'd0);
        else begin
          e = start_q.pop_front();
          chk("start_unit", 64'(start), 64'(1 << e.unit));
          chk("start_dy", 64'(dy), 64'(e.line));
          if (e.first_frame) chk("first_start_latency", 64'(cyc - launch_cyc), 64'd2);
          else if (!e.first_line)
            chk("done_to_start_gap", 64'(cyc - last_done_cyc), 64'(3 + 2 * (int'(e.unit) - prev_unit - 1)));
          prev_unit = int'(e.unit);
        end
      end
      if (lb_wr) begin
        lb_cnt++;
        if (lb_q.size() == 0) chk("lb_wr_unexpected", 64'(lb_addr), 64'hFFFF);
        else begin
          w = lb_q.pop_front();
          chk("lb_addr", 64'(lb_addr), 64'(w[12:1]));
          chk("lb_data", 64'(lb_data), 64'(w[0]));
        end
      end
      if (line_ready || frame_done) begin
        lr_cnt++;
        if (line_q.size() == 0) chk("line_ready_unexpected", 64'(dy), 64'hFFFF);
        else begin
          w = line_q.pop_front();
          chk("line_ready", 64'(line_ready), 64'd1);
          chk("line_dy", 64'(dy), 64'(w[11:0]));
          chk("frame_done_flag", 64'(frame_done), 64'(w[12]));
        end
      end
    end
  end

  // One WAIT-cycle drive of unit u; the expected line-buffer write is queued as it is driven.
  task automatic drive(input int u, input bit wr, input int dx, input bit d, input bit dn);
    if (abort) return;
    unit_wr[u]            = wr;
    unit_dx[u*12 +: 12]   = 12'(dx);
    unit_data[u]          = d;
    unit_done[u]          = dn;
    if (scen == 1) begin
      unit_wr[1] = 1'b1; unit_dx[12 +: 12] = 12'd50; unit_data[1] = 1'b1;
      unit_wr[3] = 1'b1; unit_dx[36 +: 12] = 12'd60; unit_data[3] = 1'b1;
    end
    if (wr && dx < int'(LW)) lb_q.push_back({12'(dx), d});
    if (dn) last_done_cyc = cyc;
    @(negedge clk);
    unit_wr   = '0;
    unit_done = '0;
    unit_data = '0;
  endtask

  task automatic run_unit(input int u);
    int b;
    b = 60 * u + int'(dy % 12'd7);
    if (scen == 2 && u == 2 && dy == 12'd0) begin
      // Silent unit: its WAIT ends after TIMEOUT cycles, behaving like a done on the last one.
      last_done_cyc = cyc + int'(TO) - 1;
      return;
    end
    if (scen == 1 && u == 0) begin
      drive(0, 1'b1, 319, 1'b1, 1'b0);
      drive(0, 1'b1, 320, 1'b1, 1'b0);
      drive(0, 1'b1, 7, 1'b1, 1'b1);
      return;
    end
    for (int j = 0; j < 5; j++) drive(u, 1'b1, b + 3 * j, 1'(u + j + int'(dy)), 1'b0);
    drive(u, 1'b0, 0, 1'b0, 1'b1);
  endtask

  // Unit models: respond to a start pulse one cycle later (first WAIT cycle).
  initial begin : responder
    int u;
    unit_wr = '0; unit_done = '0; unit_dx = '0; unit_data = '0;
    forever begin
      @(negedge clk);
      if (start != '0 && !abort) begin
        u = 0;
        for (int i = 0; i < int'(NU); i++) if (start[i]) u = i;
        @(negedge clk);
        run_unit(u);
      end
    end
  end

  task automatic launch(input logic [NU-1:0] m);
    bit first;
    frame_start = 1'b1;
    unit_en     = m;
    launch_cyc  = cyc;
    lb_cnt      = 0;
    lr_cnt      = 0;
    for (int l = 0; l < int'(NL); l++) begin
      first = 1'b1;
      for (int i = 0; i < int'(NU); i++) begin
        if (m[i]) begin
          start_q.push_back('{line: 12'(l), unit: 2'(i), first_line: first, first_frame: (l == 0) && first});
          first = 1'b0;
        end
      end
      line_q.push_back({l == int'(NL) - 1, 12'(l)});
    end
    @(negedge clk);
    frame_start = 1'b0;
    chk("launch_busy", 64'(busy), 64'd1);
    chk("launch_terr_cleared", 64'(timeout_err), 64'd0);
    chk("launch_dy", 64'(dy), 64'd0);
  endtask

  task automatic wait_frame(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 30000);
    chk({nm, "_frame_done"}, 64'(frame_done), 64'd1);
  endtask

  task automatic end_checks(input string nm);
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_starts_left"}, 64'(start_q.size()), 64'd0);
    chk({nm, "_writes_left"}, 64'(lb_q.size()), 64'd0);
    chk({nm, "_lines_left"}, 64'(line_q.size()), 64'd0);
    chk({nm, "_line_pulses"}, 64'(lr_cnt), 64'(NL));
  endtask

  initial begin : main
    int n;
    reset = 1'b1; frame_start = 1'b0; unit_en = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", 64'({dy, start, lb_wr, lb_addr, lb_data}), 64'd0);
    chk("reset_outputs_b", 64'({line_ready, frame_done, busy, timeout_err}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full frame, every unit enabled.
    scen = 0;
    launch(4'b1111);
    wait_frame("full");
    chk("full_terr", 64'(timeout_err), 64'd0);
    end_checks("full");
    chk("full_lb_count", 64'(lb_cnt), 64'(NL * 20));

    // Unit 2 silent on line 0.
    scen = 2;
    launch(4'b1111);
    wait_frame("timeout");
    chk("timeout_err_flag", 64'(timeout_err), 64'h4);
    end_checks("timeout");

    // Sparse mask, stray writes from disabled units, dx boundary, wr with done.
    scen = 1;
    launch(4'b0101);
    wait_frame("sparse");
    end_checks("sparse");
    chk("sparse_lb_count", 64'(lb_cnt), 64'(NL * 7));

    // Reset in WAIT on line 100.
    scen = 0;
    launch(4'b1111);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(start != '0 && dy == 12'd100) && n < 20000);
    chk("reach_line_100", 64'(dy), 64'd100);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs_a", 64'({dy, start, lb_wr, lb_addr, lb_data}), 64'd0);
    chk("midreset_outputs_b", 64'({line_ready, frame_done, busy, timeout_err}), 64'd0);
    reset = 1'b0;
    start_q.delete();
    line_q.delete();
    lb_q.delete();
    repeat (20) @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'd0);
    lb_q.delete();
    abort = 1'b0;

    // All-zero mask restart, plus a frame_start while busy that must be ignored.
    scen = 4;
    launch(4'b0000);
    repeat (30) @(negedge clk);
    chk("busy_before_ignored_start", 64'(busy), 64'd1);
    frame_start = 1'b1;
    unit_en     = 4'b1111;
    @(negedge clk);
    frame_start = 1'b0;
    wait_frame("empty");
    end_checks("empty");
    chk("empty_lb_count", 64'(lb_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
